// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory program loader.
package imem_pkg;

    // Loader FSM state encoding (IDLE=0, LOAD=1, FLUSH=2, RUN=3).
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFlush = 2'd2,
        StRun   = 2'd3
    } state_t;

    localparam int unsigned IMEM_ADDR_WIDTH = 8;
    localparam int unsigned INSTR_WIDTH     = 32;

    // Word index to byte address shift.
    localparam int unsigned BYTE_SHIFT      = 2;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: streams instruction words from a host into consecutive
// instruction-memory words, holding the core in reset until the load is done.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the len data words, one
// extra word is accepted and compared against the 32-bit wrapping sum of the
// loaded words; a mismatch aborts to IDLE with err set and the core held in reset.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [31:0]           im_addr,
    output logic [DATA_WIDTH-1:0] im_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Largest legal load length is the full memory depth.
    localparam logic [ADDR_WIDTH:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CntOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  xfer;
    logic                  len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`else
    logic                  last_word;
`endif

    assign len_ok   = (len != '0) && (len <= MaxLen);
    assign in_ready = (state_q == StLoad);
    assign xfer     = in_valid && in_ready;
`ifndef IMEM_LOADER_CHECKSUM_EN
    // len_q >= 1 whenever LOAD is active, so the subtraction cannot underflow.
    assign last_word = (cnt_q == len_q - CntOne);
`endif

    // Next-state, counter and registered write-port logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            StIdle, StRun: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = StLoad;
                        len_d   = len;
                        cnt_d   = '0;
                        err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (cnt_q == len_q) begin
                        // Checksum word: compared, never written.
                        if (in_data == sum_q) begin
                            state_d = StFlush;
                        end else begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = cnt_q[ADDR_WIDTH-1:0];
                        wdata_d = in_data;
                        sum_d   = sum_q + in_data;
                        cnt_d   = cnt_q + CntOne;
                    end
`else
                    we_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_WIDTH-1:0];
                    wdata_d = in_data;
                    cnt_d   = cnt_q + CntOne;
                    if (last_word) begin
                        state_d = StFlush;
                    end
`endif
                end
            end
            StFlush: begin
                state_d = StRun;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any load immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            we_q    <= we_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign im_we      = we_q;
    assign im_addr    = 32'(waddr_q) << BYTE_SHIFT;
    assign im_wdata   = wdata_q;
    assign core_rst_n = (state_q == StRun);
    assign busy       = (state_q == StLoad) || (state_q == StFlush);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// loads, checked against expectations derived from the load rules.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK_OK = 1;
`else
    localparam int CK_OK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          vmode;
    bit          vpat[$];
    logic [31:0] words[$];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit pick_valid();
        if (vmode == 0) return 1'b1;
        if (vmode == 1) return (vpat.size() > 0) ? vpat.pop_front() : 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // ck: 0 no checksum word, 1 correct checksum, 2 wrong checksum.
    task automatic do_load(input int n, input int ck);
        int          idx;
        int          cyc;
        int          total;
        bit          v;
        logic [31:0] sum;
        logic [31:0] ckword;
        sum = '0;
        for (int i = 0; i < n; i++) sum = sum + words[i];
        ckword = (ck == 2) ? sum + 32'd1 : sum;
        total  = n + ((ck != 0) ? 1 : 0);

        start = 1'b1;
        len   = 9'(n);
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        check_eq("start_busy", busy, 1);
        check_eq("start_ready", in_ready, 1);
        check_eq("start_core_rst", core_rst_n, 0);
        check_eq("start_err_clr", err, 0);
        check_eq("start_done", done, 0);

        idx = 0;
        cyc = 0;
        while (idx < total && cyc < 10 * total + 40) begin
            v        = pick_valid();
            in_valid = v;
            in_data  = !v ? $urandom : (idx < n) ? words[idx] : ckword;
            // Start during LOAD must be ignored, even with an illegal length.
            if (vmode == 2 && $urandom_range(0, 5) == 0) start = 1'b1;
            @(negedge clk);
            cyc++;
            start    = 1'b0;
            in_valid = 1'b0;
            if (v && idx < n) begin
                check_eq("wr_we", im_we, 1);
                check_eq("wr_addr", im_addr, 32'(idx) << 2);
                check_eq("wr_data", im_wdata, words[idx]);
            end else begin
                check_eq("nowr_we", im_we, 0);
            end
            if (v) idx++;
            if (idx < total) begin
                check_eq("ld_ready", in_ready, 1);
                check_eq("ld_busy", busy, 1);
            end
        end
        check_eq("ld_count", idx, total);

        if (ck == 2) begin
            check_eq("ckbad_err", err, 1);
            check_eq("ckbad_busy", busy, 0);
            check_eq("ckbad_ready", in_ready, 0);
            check_eq("ckbad_core", core_rst_n, 0);
            repeat (3) begin
                @(negedge clk);
                check_eq("ckbad_done", done, 0);
                check_eq("ckbad_we", im_we, 0);
                check_eq("ckbad_core_hold", core_rst_n, 0);
            end
        end else begin
            check_eq("fl_ready", in_ready, 0);
            check_eq("fl_busy", busy, 1);
            check_eq("fl_core", core_rst_n, 0);
            check_eq("fl_done", done, 0);
            if (vmode == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check_eq("run_done", done, 1);
            check_eq("run_core", core_rst_n, 1);
            check_eq("run_busy", busy, 0);
            check_eq("run_we", im_we, 0);
            check_eq("run_err", err, 0);
            @(negedge clk);
            check_eq("run_done_once", done, 0);
            check_eq("run_core_hold", core_rst_n, 1);
        end
    endtask

    task automatic check_bad_len(input int l, input bit in_run);
        start = 1'b1;
        len   = 9'(l);
        @(negedge clk);
        start = 1'b0;
        len   = '0;
        check_eq("bad_err", err, 1);
        check_eq("bad_busy", busy, 0);
        check_eq("bad_ready", in_ready, 0);
        check_eq("bad_we", im_we, 0);
        check_eq("bad_core", core_rst_n, 32'(in_run));
        @(negedge clk);
        check_eq("bad_err_sticky", err, 1);
        check_eq("bad_we2", im_we, 0);
        check_eq("bad_core2", core_rst_n, 32'(in_run));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        vmode    = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", in_ready, 0);
        check_eq("rst_we", im_we, 0);
        check_eq("rst_addr", im_addr, 0);
        check_eq("rst_wdata", im_wdata, 0);
        check_eq("rst_core", core_rst_n, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_core", core_rst_n, 0);
        check_eq("idle_ready", in_ready, 0);

        check_bad_len(0, 1'b0);
        check_bad_len(257, 1'b0);

        words = '{32'hE3A00001, 32'hE2800001, 32'hEAFFFFFE};
        vmode = 0;
        do_load(3, CK_OK);

        fill_random(4);
        vmode = 1;
        vpat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_load(4, CK_OK);

        words = '{32'hDEADBEEF};
        vmode = 0;
        do_load(1, CK_OK);

        // Reset in the middle of a 5-word load.
        fill_random(5);
        start = 1'b1;
        len   = 9'd5;
        @(negedge clk);
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b1;
        in_data  = words[0];
        @(negedge clk);
        in_data = words[1];
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pre_rst_we", im_we, 1);
        check_eq("pre_rst_addr", im_addr, 32'h4);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_ready", in_ready, 0);
        check_eq("arst_we", im_we, 0);
        check_eq("arst_addr", im_addr, 0);
        check_eq("arst_wdata", im_wdata, 0);
        check_eq("arst_core", core_rst_n, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_core", core_rst_n, 0);
        do_load(5, CK_OK);

        // Full-depth load.
        fill_random(256);
        vmode = 0;
        do_load(256, CK_OK);

        for (int r = 0; r < 6; r++) begin
            fill_random($urandom_range(1, 24));
            vmode = 2;
            do_load(words.size(), CK_OK);
            check_bad_len($urandom_range(257, 511), 1'b1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        words = '{32'h00000001, 32'h00000002};
        vmode = 0;
        do_load(2, 1);
        do_load(2, 2);
        fill_random($urandom_range(1, 16));
        vmode = 2;
        do_load(words.size(), 1);
`endif

        repeat (5) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            @(negedge clk);
            check_eq("idle_run_we", im_we, 0);
            check_eq("idle_run_ready", in_ready, 0);
            check_eq("idle_run_done", done, 0);
            check_eq("idle_run_core", core_rst_n, 1);
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
